clip_sequencer: RTL and testbench

//  Single-plane triangle clipper controller (Sutherland-Hodgman). Accepts one triangle plus a

---
 rtl/clip_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_clip_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_sequencer.sv
// clip_sequencer: single-plane Sutherland-Hodgman triangle clip controller.
// Classifies three vertices against one plane, walks the three edges, requests
// intersections for crossing edges and streams out a 0/3/4-vertex polygon.
// Optional feature macro: CLIP_STATS_EN (saturating statistics counters).
module clip_sequencer #(
  parameter int WIDTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tri_valid_i,
  output logic                 tri_ready_o,
  input  logic [4*WIDTH-1:0]   tri_v0_i,
  input  logic [4*WIDTH-1:0]   tri_v1_i,
  input  logic [4*WIDTH-1:0]   tri_v2_i,
  input  logic [4*WIDTH-1:0]   plane_i,
  output logic                 isect_start_o,
  output logic [4*WIDTH-1:0]   isect_v1_o,
  output logic [4*WIDTH-1:0]   isect_v2_o,
  input  logic                 isect_done_i,
  input  logic [4*WIDTH-1:0]   isect_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*WIDTH-1:0]   out_vtx_o,
  output logic                 out_last_o,
  output logic                 culled_o,
  output logic [STAT_W-1:0]    stat_in_o,
  output logic [STAT_W-1:0]    stat_culled_o,
  output logic [STAT_W-1:0]    stat_clipped_o
);

  localparam int VW = 4 * WIDTH;
  localparam int DW = 2 * WIDTH + 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLASSIFY,
    S_EDGE,
    S_EMIT_V,
    S_CHECK,
    S_ISECT,
    S_WAIT,
    S_EMIT_I,
    S_NEXT
  } state_e;

  state_e          state_q;
  logic [VW-1:0]   v0_q, v1_q, v2_q, plane_q;
  logic [2:0]      in_q;
  logic [1:0]      e_q;
  logic [1:0]      emit_cnt_q;
  logic [1:0]      last_idx_q;
  logic            tri_ready_q;
  logic            isect_start_q;
  logic [VW-1:0]   isect_v1_q, isect_v2_q;
  logic            out_valid_q;
  logic [VW-1:0]   out_vtx_q;
  logic            out_last_q;
  logic            culled_q;

  logic signed [DW-1:0] dist0, dist1, dist2;
  logic [2:0]      in_d;
  logic [1:0]      n_in_d;
  logic [VW-1:0]   v_e, v_e1;
  logic            in_e, in_e1;

  // Plane distance a*x+b*y+c*z+d*w at full precision (cannot overflow DW bits)
  function automatic logic signed [DW-1:0] dist_f(input logic [VW-1:0] v,
                                                  input logic [VW-1:0] p);
    logic signed [DW-1:0]    acc;
    logic signed [WIDTH-1:0] pc, vc;
    acc = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      pc  = p[k*WIDTH +: WIDTH];
      vc  = v[k*WIDTH +: WIDTH];
      acc = acc + DW'(pc) * DW'(vc);
    end
    return acc;
  endfunction

  // Vertex classification from the captured triangle; dist == 0 counts as inside
  always_comb begin
    dist0  = dist_f(v0_q, plane_q);
    dist1  = dist_f(v1_q, plane_q);
    dist2  = dist_f(v2_q, plane_q);
    in_d   = {~dist2[DW-1], ~dist1[DW-1], ~dist0[DW-1]};
    n_in_d = {1'b0, in_d[0]} + {1'b0, in_d[1]} + {1'b0, in_d[2]};
  end

  // Current edge endpoints and their inside flags
  always_comb begin
    v_e   = v0_q;
    v_e1  = v1_q;
    in_e  = in_q[0];
    in_e1 = in_q[1];
    case (e_q)
      2'd1: begin
        v_e   = v1_q;
        v_e1  = v2_q;
        in_e  = in_q[1];
        in_e1 = in_q[2];
      end
      2'd2: begin
        v_e   = v2_q;
        v_e1  = v0_q;
        in_e  = in_q[2];
        in_e1 = in_q[0];
      end
      default: ;
    endcase
  end

  // Edge-walk controller with registered outputs. After the handshake of the
  // final vertex nothing else can be emitted, so it returns straight to IDLE
  // instead of stepping through the remaining CHECK/NEXT states.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      v0_q          <= '0;
      v1_q          <= '0;
      v2_q          <= '0;
      plane_q       <= '0;
      in_q          <= '0;
      e_q           <= '0;
      emit_cnt_q    <= '0;
      last_idx_q    <= '0;
      tri_ready_q   <= 1'b1;
      isect_start_q <= 1'b0;
      isect_v1_q    <= '0;
      isect_v2_q    <= '0;
      out_valid_q   <= 1'b0;
      out_vtx_q     <= '0;
      out_last_q    <= 1'b0;
      culled_q      <= 1'b0;
    end else begin
      isect_start_q <= 1'b0;
      culled_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tri_valid_i) begin
            v0_q        <= tri_v0_i;
            v1_q        <= tri_v1_i;
            v2_q        <= tri_v2_i;
            plane_q     <= plane_i;
            tri_ready_q <= 1'b0;
            state_q     <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          in_q       <= in_d;
          e_q        <= '0;
          emit_cnt_q <= '0;
          last_idx_q <= (n_in_d == 2'd2) ? 2'd3 : 2'd2;
          if (n_in_d == 2'd0) begin
            culled_q    <= 1'b1;
            tri_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_EDGE;
          end
        end
        S_EDGE: begin
          if (in_e) begin
            out_valid_q <= 1'b1;
            out_vtx_q   <= v_e;
            out_last_q  <= (emit_cnt_q == last_idx_q);
            state_q     <= S_EMIT_V;
          end else begin
            state_q <= S_CHECK;
          end
        end
        S_EMIT_V, S_EMIT_I: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            emit_cnt_q  <= emit_cnt_q + 2'd1;
            if (out_last_q) begin
              tri_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              state_q <= (state_q == S_EMIT_V) ? S_CHECK : S_NEXT;
            end
          end
        end
        S_CHECK: begin
          if (in_e != in_e1) begin
            isect_start_q <= 1'b1;
            isect_v1_q    <= v_e;
            isect_v2_q    <= v_e1;
            state_q       <= S_ISECT;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_ISECT: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (isect_done_i) begin
            out_valid_q <= 1'b1;
            out_vtx_q   <= isect_result_i;
            out_last_q  <= (emit_cnt_q == last_idx_q);
            state_q     <= S_EMIT_I;
          end
        end
        S_NEXT: begin
          if (e_q == 2'd2) begin
            tri_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            e_q     <= e_q + 2'd1;
            state_q <= S_EDGE;
          end
        end
        default: begin
          tri_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign tri_ready_o   = tri_ready_q;
  assign isect_start_o = isect_start_q;
  assign isect_v1_o    = isect_v1_q;
  assign isect_v2_o    = isect_v2_q;
  assign out_valid_o   = out_valid_q;
  assign out_vtx_o     = out_vtx_q;
  assign out_last_o    = out_last_q;
  assign culled_o      = culled_q;

`ifdef CLIP_STATS_EN
  logic [STAT_W-1:0] stat_in_q, stat_culled_q, stat_clipped_q;

  // Saturating triangle statistics, updated in the classify cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_in_q      <= '0;
      stat_culled_q  <= '0;
      stat_clipped_q <= '0;
    end else if (state_q == S_CLASSIFY) begin
      if (stat_in_q != '1) stat_in_q <= stat_in_q + 1'b1;
      if (n_in_d == 2'd0 && stat_culled_q != '1)
        stat_culled_q <= stat_culled_q + 1'b1;
      if ((n_in_d == 2'd1 || n_in_d == 2'd2) && stat_clipped_q != '1)
        stat_clipped_q <= stat_clipped_q + 1'b1;
    end
  end

  assign stat_in_o      = stat_in_q;
  assign stat_culled_o  = stat_culled_q;
  assign stat_clipped_o = stat_clipped_q;
`else
  assign stat_in_o      = '0;
  assign stat_culled_o  = '0;
  assign stat_clipped_o = '0;
`endif

endmodule

// File: tb/tb_clip_sequencer.sv
// Self-checking bench for clip_sequencer: reference polygon model, intersection
// stub, random backpressure, mid-operation reset and randomized triangles.
module tb_clip_sequencer;

  localparam int WIDTH  = 16;
  localparam int STAT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid_i = 1'b0;
  logic        tri_ready_o;
  logic [63:0] tri_v0_i = '0, tri_v1_i = '0, tri_v2_i = '0, plane_i = '0;
  logic        isect_start_o;
  logic [63:0] isect_v1_o, isect_v2_o;
  logic        isect_done_i = 1'b0;
  logic [63:0] isect_result_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [63:0] out_vtx_o;
  logic        out_last_o;
  logic        culled_o;
  logic [STAT_W-1:0] stat_in_o, stat_culled_o, stat_clipped_o;

  clip_sequencer #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o),
    .tri_v0_i(tri_v0_i), .tri_v1_i(tri_v1_i), .tri_v2_i(tri_v2_i), .plane_i(plane_i),
    .isect_start_o(isect_start_o), .isect_v1_o(isect_v1_o), .isect_v2_o(isect_v2_o),
    .isect_done_i(isect_done_i), .isect_result_i(isect_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_vtx_o(out_vtx_o), .out_last_o(out_last_o), .culled_o(culled_o),
    .stat_in_o(stat_in_o), .stat_culled_o(stat_culled_o), .stat_clipped_o(stat_clipped_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [64:0]  exp_out[$];   // {last, vertex}
  logic [127:0] exp_pair[$];  // {v1, v2}
  int exp_cull = 0;
  int st_in = 0, st_cul = 0, st_clip = 0;

  int          pend = 0;
  int          cnt = 0;
  int          delay_cfg = 1;
  bit          spur_en = 1'b1;
  logic [63:0] pv1 = '0, pv2 = '0;
  bit          bp_mode = 1'b0;
  int          stall_req = 0;
  bit          stall_hold = 1'b0;
  logic [64:0] held = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rfun(input logic [63:0] a, input logic [63:0] b);
    return a ^ {b[15:0], b[63:16]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  function automatic longint comp(input logic [63:0] p, input int k);
    logic signed [15:0] t;
    t = p[k*16 +: 16];
    return longint'(t);
  endfunction

  function automatic logic [63:0] mkv(input int x);
    logic [15:0] xs;
    xs = 16'(x);
    return {16'h0010, 16'h0000, 16'h0000, xs};
  endfunction

  // Reference polygon: Sutherland-Hodgman over the three edges
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] p, output int n);
    logic [63:0] v[3];
    bit          inb[3];
    int          nin;
    logic [63:0] lst[$];
    v[0] = a; v[1] = b; v[2] = c;
    nin = 0;
    for (int i = 0; i < 3; i++) begin
      longint d;
      d = 0;
      for (int k = 0; k < 4; k++) d += comp(p, k) * comp(v[i], k);
      inb[i] = (d >= 0);
      nin += int'(inb[i]);
    end
    st_in++;
    n = 0;
    if (nin == 0) begin
      exp_cull++;
      st_cul++;
    end else begin
      if (nin < 3) st_clip++;
      for (int e = 0; e < 3; e++) begin
        int j;
        j = (e + 1) % 3;
        if (inb[e]) lst.push_back(v[e]);
        if (inb[e] != inb[j]) begin
          lst.push_back(rfun(v[e], v[j]));
          exp_pair.push_back({v[e], v[j]});
        end
      end
      n = lst.size();
      for (int i = 0; i < n; i++) exp_out.push_back({(i == n - 1), lst[i]});
    end
  endtask

  // Output scoreboard, stability under stall, cull pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check("out_valid_held", out_valid_o, 1'b1);
        check("out_stable", {out_last_o, out_vtx_o}, held);
      end
      stall_hold = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          if (exp_out.size() == 0) check("out_unexpected", 1'b1, 1'b0);
          else check("out_vtx", {out_last_o, out_vtx_o}, exp_out.pop_front());
        end else begin
          stall_hold = 1'b1;
          held = {out_last_o, out_vtx_o};
        end
      end
      if (culled_o) begin
        check("cull_expected", exp_cull > 0, 1'b1);
        if (exp_cull > 0) exp_cull--;
      end
    end
  end

  // Intersection datapath stub
  initial begin
    forever begin
      @(negedge clk);
      isect_done_i = 1'b0;
      if (rst_n) begin
        if (isect_start_o) begin
          check("isect_single", pend, 0);
          if (exp_pair.size() == 0) begin
            check("isect_unexpected", 1'b1, 1'b0);
            {pv1, pv2} = {isect_v1_o, isect_v2_o};
          end else begin
            check("isect_pair", {isect_v1_o, isect_v2_o}, exp_pair[0]);
            {pv1, pv2} = exp_pair.pop_front();
          end
          pend = 1;
          cnt  = delay_cfg;
        end else if (pend != 0) begin
          check("isect_hold", {isect_v1_o, isect_v2_o}, {pv1, pv2});
          cnt--;
          if (cnt == 0) begin
            isect_done_i   = 1'b1;
            isect_result_i = rfun(pv1, pv2);
            pend = 0;
          end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
          isect_done_i   = 1'b1;
          isect_result_i = {$urandom(), $urandom()};
        end
      end
    end
  end

  // Downstream ready: forced stalls or random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        out_ready_i = 1'b0;
        stall_req--;
      end else begin
        out_ready_i = bp_mode ? ($urandom_range(0, 99) < 65) : 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(exp_out.size() == 0 && exp_pair.size() == 0 && exp_cull == 0 &&
             tri_ready_o && !out_valid_o && pend == 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", k < 2000, 1'b1);
  endtask

  task automatic run_tri(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] p, input bit wait_done, output int n);
    int k;
    model(a, b, c, p, n);
    @(negedge clk);
    tri_v0_i = a; tri_v1_i = b; tri_v2_i = c; plane_i = p;
    tri_valid_i = 1'b1;
    k = 0;
    while (!tri_ready_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", k < 2000, 1'b1);
    @(posedge clk);
    #1 tri_valid_i = 1'b0;
    @(negedge clk);
    check("ready_low_after_accept", tri_ready_o, 1'b0);
    if (n == 0) begin
      @(negedge clk);
      check("ready_back_after_cull", tri_ready_o, 1'b1);
    end
    if (wait_done) wait_idle();
  endtask

  task automatic check_stats(input string name);
`ifdef CLIP_STATS_EN
    check({name, "_stat_in"}, stat_in_o, st_in);
    check({name, "_stat_culled"}, stat_culled_o, st_cul);
    check({name, "_stat_clipped"}, stat_clipped_o, st_clip);
`else
    check({name, "_stats_zero"}, {stat_in_o, stat_culled_o, stat_clipped_o}, '0);
`endif
  endtask

  localparam logic [63:0] PX = 64'h0000_0000_0000_0010;

  initial begin
    int n, k;
    #12;
    check("reset_ctrl", {tri_ready_o, out_valid_o, out_last_o, isect_start_o, culled_o}, 5'b10000);
    check("reset_vec", {isect_v1_o, isect_v2_o, out_vtx_o}, '0);
    check_stats("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_tri(mkv(1), mkv(2), mkv(3), PX, 1'b1, n);
    check("model_n_all_in", n, 3);
    run_tri(mkv(-1), mkv(-2), mkv(-3), PX, 1'b1, n);
    check("model_n_all_out", n, 0);
    run_tri(mkv(2), mkv(-2), mkv(-2), PX, 1'b1, n);
    check("model_n_one_in", n, 3);
    run_tri(mkv(2), mkv(2), mkv(-2), PX, 1'b1, n);
    check("model_n_two_in", n, 4);
    run_tri(mkv(0), mkv(-2), mkv(-2), PX, 1'b1, n);
    check("model_n_zero_dist", n, 3);
    run_tri(mkv(0), mkv(0), mkv(0), PX, 1'b1, n);
    check("model_n_all_zero", n, 3);

    // Long done latency plus a 5-cycle stall mid-polygon
    delay_cfg = 7;
    run_tri(mkv(2), mkv(2), mkv(-2), PX, 1'b0, n);
    k = 0;
    while (exp_out.size() > 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    stall_req = 5;
    wait_idle();

    // Reset while waiting on the intersection datapath
    run_tri(mkv(2), mkv(-2), mkv(-2), PX, 1'b0, n);
    k = 0;
    while (pend == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wait_reached", pend, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend = 0;
    isect_done_i = 1'b0;
    exp_out.delete();
    exp_pair.delete();
    exp_cull = 0;
    st_in = 0; st_cul = 0; st_clip = 0;
    #1;
    check("midreset_ctrl", {tri_ready_o, out_valid_o, out_last_o, isect_start_o, culled_o}, 5'b10000);
    check("midreset_vec", {isect_v1_o, isect_v2_o, out_vtx_o}, '0);
    check_stats("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    delay_cfg = 1;

    run_tri(mkv(1), mkv(2), mkv(3), PX, 1'b1, n);
    run_tri(mkv(-1), mkv(-2), mkv(-3), PX, 1'b1, n);
    run_tri(mkv(2), mkv(-2), mkv(-2), PX, 1'b1, n);
    run_tri(mkv(2), mkv(2), mkv(-2), PX, 1'b1, n);
`ifdef CLIP_STATS_EN
    check("stats_literal", {stat_in_o, stat_culled_o, stat_clipped_o}, {16'd4, 16'd1, 16'd2});
`endif
    check_stats("after_reset");

    // Randomized triangles, planes, latencies and backpressure
    for (int t = 0; t < 150; t++) begin
      logic [63:0] a, b, c, p;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      c = {$urandom(), $urandom()};
      p = ($urandom_range(0, 15) == 0) ? 64'h0 : {$urandom(), $urandom()};
      delay_cfg = $urandom_range(1, 4);
      bp_mode = $urandom_range(0, 1);
      run_tri(a, b, c, p, $urandom_range(0, 1), n);
    end
    wait_idle();
    check_stats("final");
    check("queues_empty", exp_out.size() + exp_pair.size() + exp_cull, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
